// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum row buffer.
package psum_pkg;

    localparam int PSUM_DATA_WIDTH  = 25;
    localparam int PSUM_MIN_ROW_LEN = 5;

    typedef enum logic [0:0] {
        PSUM_IDLE = 1'b0,
        PSUM_RUN  = 1'b1
    } psum_state_t;

    typedef logic signed [PSUM_DATA_WIDTH-1:0] psum_t;

endpackage

// File: rtl/psum_row_ram.sv
// Simple dual-port psum storage: one write port and one registered read port.
// On a same-address read/write in one cycle the read returns the old word.
module psum_row_ram
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Write port; storage contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read; non-blocking ordering yields the pre-write word on collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/psum_row_buffer.sv
// Partial-sum row buffer: feeds stored psums to the adder tree and captures
// its results, accumulating over cfg_num_pass passes. Pass 0 reads zero and
// the final pass streams results out on res_valid/res_data.
// Optional feature macro: PSUM_RELU_EN (ReLU applied to final-pass results).
module psum_row_buffer
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH  = PSUM_DATA_WIDTH,
    parameter int DEPTH       = 64,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int PASS_WIDTH  = 8,
    parameter int MIN_ROW_LEN = PSUM_MIN_ROW_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   cfg_row_len,
    input  logic [PASS_WIDTH-1:0] cfg_num_pass,
    input  logic                  start,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  sum_valid,
    input  logic [DATA_WIDTH-1:0] sum_data,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH:0] ROW_MIN = (ADDR_WIDTH+1)'(MIN_ROW_LEN);
    localparam logic [ADDR_WIDTH:0] ROW_MAX = (ADDR_WIDTH+1)'(DEPTH);

    psum_state_t state_r, state_nxt_s;

    logic [ADDR_WIDTH:0]   row_len_r;
    logic [PASS_WIDTH-1:0] num_pass_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r, wr_ptr_r;
    logic [PASS_WIDTH-1:0] rd_pass_r, wr_pass_r;
    logic                  zero_sel_r;
    logic                  res_valid_r, done_r, err_r;
    logic [DATA_WIDTH-1:0] res_data_r;

    logic                  idle_s, run_s, cfg_ok_s, start_ok_s, start_bad_s;
    logic [ADDR_WIDTH:0]   row_last_s;
    logic [PASS_WIDTH-1:0] pass_last_s;
    logic [PASS_WIDTH:0]   rd_pass_ext_s, wr_pass_p1_s;
    logic                  rd_block_s, rd_go_s, rd_err_s, rd_wrap_s;
    logic                  wr_go_s, wr_err_s, wr_wrap_s, wr_final_s;
    logic                  ram_we_s, res_go_s, row_end_s, new_err_s;
    logic [DATA_WIDTH-1:0] ram_q_s, res_val_s;

    assign idle_s      = (state_r == PSUM_IDLE);
    assign run_s       = (state_r == PSUM_RUN);
    assign cfg_ok_s    = (cfg_row_len >= ROW_MIN) && (cfg_row_len <= ROW_MAX) &&
                         (cfg_num_pass != {PASS_WIDTH{1'b0}});
    assign start_ok_s  = start && idle_s && cfg_ok_s;
    assign start_bad_s = start && idle_s && !cfg_ok_s;

    assign row_last_s  = row_len_r - (ADDR_WIDTH+1)'(1);
    assign pass_last_s = num_pass_r - PASS_WIDTH'(1);

    // A read of pass p column c needs pass p-1 column c already written
    assign rd_pass_ext_s = {1'b0, rd_pass_r};
    assign wr_pass_p1_s  = {1'b0, wr_pass_r} + (PASS_WIDTH+1)'(1);
    assign rd_block_s    = !run_s || (rd_pass_r == num_pass_r) ||
                           (rd_pass_ext_s > wr_pass_p1_s) ||
                           ((rd_pass_ext_s == wr_pass_p1_s) && (rd_ptr_r >= wr_ptr_r));
    assign rd_go_s   = rd_en && !rd_block_s;
    assign rd_err_s  = rd_en && rd_block_s;
    assign rd_wrap_s = ({1'b0, rd_ptr_r} == row_last_s);

    assign wr_go_s    = sum_valid && run_s;
    assign wr_err_s   = sum_valid && idle_s;
    assign wr_wrap_s  = ({1'b0, wr_ptr_r} == row_last_s);
    assign wr_final_s = (wr_pass_r == pass_last_s);
    assign ram_we_s   = wr_go_s && !wr_final_s;
    assign res_go_s   = wr_go_s && wr_final_s;
    assign row_end_s  = res_go_s && wr_wrap_s;
    assign new_err_s  = start_bad_s || rd_err_s || wr_err_s;

`ifdef PSUM_RELU_EN
    assign res_val_s = sum_data[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : sum_data;
`else
    assign res_val_s = sum_data;
`endif

    psum_row_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we_s),
        .waddr (wr_ptr_r),
        .wdata (sum_data),
        .re    (rd_go_s),
        .raddr (rd_ptr_r),
        .rdata (ram_q_s)
    );

    // FSM next state: a legal start enters RUN, the last final-pass write leaves it
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            PSUM_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = PSUM_RUN;
                end else begin
                    state_nxt_s = PSUM_IDLE;
                end
            end
            PSUM_RUN: begin
                if (row_end_s) begin
                    state_nxt_s = PSUM_IDLE;
                end else begin
                    state_nxt_s = PSUM_RUN;
                end
            end
            default: state_nxt_s = PSUM_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= PSUM_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Row configuration, latched only on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_len_r  <= '0;
            num_pass_r <= '0;
        end else if (start_ok_s) begin
            row_len_r  <= cfg_row_len;
            num_pass_r <= cfg_num_pass;
        end
    end

    // Read and write pointer/pass counters; each pass counter steps on its pointer wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r  <= '0;
            rd_pass_r <= '0;
            wr_ptr_r  <= '0;
            wr_pass_r <= '0;
        end else if (start_ok_s) begin
            rd_ptr_r  <= '0;
            rd_pass_r <= '0;
            wr_ptr_r  <= '0;
            wr_pass_r <= '0;
        end else begin
            if (rd_go_s) begin
                if (rd_wrap_s) begin
                    rd_ptr_r  <= '0;
                    rd_pass_r <= rd_pass_r + PASS_WIDTH'(1);
                end else begin
                    rd_ptr_r  <= rd_ptr_r + ADDR_WIDTH'(1);
                end
            end
            if (wr_go_s) begin
                if (wr_wrap_s) begin
                    wr_ptr_r  <= '0;
                    wr_pass_r <= wr_pass_r + PASS_WIDTH'(1);
                end else begin
                    wr_ptr_r  <= wr_ptr_r + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Output registers: result stream, done pulse, pass-0 zero select and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
            done_r      <= 1'b0;
            zero_sel_r  <= 1'b1;
            err_r       <= 1'b0;
        end else begin
            res_valid_r <= res_go_s;
            done_r      <= row_end_s;
            if (res_go_s) begin
                res_data_r <= res_val_s;
            end
            if (rd_go_s) begin
                zero_sel_r <= (rd_pass_r == {PASS_WIDTH{1'b0}});
            end
            if (start_ok_s) begin
                err_r <= new_err_s;
            end else begin
                err_r <= err_r | new_err_s;
            end
        end
    end

    // Zero select and RAM read register update together, so fifo_data holds between reads
    assign fifo_data = zero_sel_r ? {DATA_WIDTH{1'b0}} : ram_q_s;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign done      = done_r;
    assign err       = err_r;
    assign busy      = run_s;

endmodule

// File: tb/tb_psum_row_buffer.sv
// Directed self-checking bench for psum_row_buffer.
module tb_psum_row_buffer;

    localparam int DW = 25;
    localparam int AW = 6;
    localparam int PW = 8;
    localparam logic [DW-1:0] M5 = 25'h1FFFFFB;   // -5
`ifdef PSUM_RELU_EN
    localparam logic [DW-1:0] EXP_NEG_RES = 25'h0;
`else
    localparam logic [DW-1:0] EXP_NEG_RES = 25'h1FFFFFB;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW:0]   cfg_row_len;
    logic [PW-1:0] cfg_num_pass;
    logic          start, rd_en, sum_valid;
    logic [DW-1:0] sum_data, fifo_data, res_data;
    logic          res_valid, busy, done, err;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] fd_q [0:255];

    always #5 clk = ~clk;

    psum_row_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_row_len  (cfg_row_len),
        .cfg_num_pass (cfg_num_pass),
        .start        (start),
        .rd_en        (rd_en),
        .fifo_data    (fifo_data),
        .sum_valid    (sum_valid),
        .sum_data     (sum_data),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        rd_en     = 1'b0;
        sum_valid = 1'b0;
        sum_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start(input int rl, input int np);
        cfg_row_len  = (AW+1)'(rl);
        cfg_num_pass = PW'(np);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: adder model sum = fifo_data + 10 ; mode 1: sums 1..N ; mode 2: constant -5
    task automatic run_row(input int rl, input int np, input int mode, input int abort_at);
        int total, n_res, n_done, p;
        logic [DW-1:0] exp_v;
        total  = rl * np;
        n_res  = 0;
        n_done = 0;
        do_start(rl, np);
        for (int c = 0; c < total + 8; c++) begin
            if (c == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("async_rst_fifo_data", 32'(fifo_data), 32'h0);
                check_eq("async_rst_res_valid", 32'(res_valid), 32'h0);
                check_eq("async_rst_res_data", 32'(res_data), 32'h0);
                check_eq("async_rst_busy", 32'(busy), 32'h0);
                check_eq("async_rst_done", 32'(done), 32'h0);
                check_eq("async_rst_err", 32'(err), 32'h0);
                idle_inputs();
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            if (c >= 1 && c - 1 < total) begin
                fd_q[c-1] = fifo_data;
                p = (c - 1) / rl;
                if (p == 0) exp_v = '0;
                else if (mode == 2) exp_v = M5;
                else exp_v = DW'(10 * p);
                check_eq("fifo_data", 32'(fifo_data), 32'(exp_v));
            end
            if (res_valid) begin
                if (mode == 1) exp_v = DW'(n_res + 1);
                else if (mode == 2) exp_v = EXP_NEG_RES;
                else exp_v = DW'(10 * np);
                check_eq("res_data", 32'(res_data), 32'(exp_v));
                n_res++;
            end
            if (done) begin
                n_done++;
                check_eq("done_with_last_res", n_res, rl);
                check_eq("done_res_valid", 32'(res_valid), 32'h1);
            end
            rd_en = (c < total);
            if (c >= 4 && c - 4 < total) begin
                sum_valid = 1'b1;
                if (mode == 1) sum_data = DW'(c - 3);
                else if (mode == 2) sum_data = M5;
                else sum_data = fd_q[c-4] + DW'(10);
            end else begin
                sum_valid = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("res_count", n_res, rl);
        check_eq("done_count", n_done, 1);
        check_eq("row_end_busy", 32'(busy), 32'h0);
        check_eq("row_end_err", 32'(err), 32'h0);
    endtask

    initial begin
        rst_n        = 1'b0;
        cfg_row_len  = '0;
        cfg_num_pass = '0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_fifo_data", 32'(fifo_data), 32'h0);
        check_eq("rst_res_valid", 32'(res_valid), 32'h0);
        check_eq("rst_res_data", 32'(res_data), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single pass, results 1..8
        run_row(8, 1, 1, -1);
        // 2: three passes through the +10 adder model -> 30
        run_row(8, 3, 0, -1);
        // 3: negative final sum, stored -5 read back in pass 1
        run_row(5, 2, 2, -1);

        // 4: overtake guard; RAM[0] still holds -5 from the previous row
        do_start(5, 2);
        for (int k = 0; k < 5; k++) begin
            rd_en = 1'b1;
            @(negedge clk);
        end
        check_eq("pre_overtake_err", 32'(err), 32'h0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check_eq("overtake_err", 32'(err), 32'h1);
        check_eq("overtake_fifo_held", 32'(fifo_data), 32'h0);
        for (int k = 0; k < 5; k++) begin
            sum_valid = 1'b1;
            sum_data  = DW'(100 + k);
            @(negedge clk);
        end
        sum_valid = 1'b0;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check_eq("overtake_rd_ptr_kept", 32'(fifo_data), 32'd100);
        check_eq("err_sticky", 32'(err), 32'h1);
        check_eq("overtake_busy", 32'(busy), 32'h1);
        do_reset();

        // 5: config checks and start ignored while running
        do_start(3, 1);
        check_eq("short_row_err", 32'(err), 32'h1);
        check_eq("short_row_busy", 32'(busy), 32'h0);
        do_start(5, 1);
        check_eq("legal_start_err", 32'(err), 32'h0);
        check_eq("legal_start_busy", 32'(busy), 32'h1);
        do_start(8, 1);
        check_eq("run_start_busy", 32'(busy), 32'h1);
        check_eq("run_start_err", 32'(err), 32'h0);
        for (int k = 0; k < 5; k++) begin
            sum_valid = 1'b1;
            sum_data  = DW'(k + 1);
            @(negedge clk);
            check_eq("run5_res_valid", 32'(res_valid), 32'h1);
            check_eq("run5_res_data", 32'(res_data), k + 1);
            check_eq("run5_done", 32'(done), (k == 4) ? 32'h1 : 32'h0);
        end
        sum_valid = 1'b0;
        @(negedge clk);
        check_eq("run5_idle", 32'(busy), 32'h0);
        do_start(65, 1);
        check_eq("long_row_err", 32'(err), 32'h1);
        check_eq("long_row_busy", 32'(busy), 32'h0);
        do_start(64, 1);
        check_eq("max_row_err", 32'(err), 32'h0);
        check_eq("max_row_busy", 32'(busy), 32'h1);
        do_reset();
        do_start(5, 0);
        check_eq("zero_pass_err", 32'(err), 32'h1);
        check_eq("zero_pass_busy", 32'(busy), 32'h0);
        do_reset();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check_eq("idle_rd_err", 32'(err), 32'h1);
        do_reset();
        sum_valid = 1'b1;
        sum_data  = DW'(7);
        @(negedge clk);
        sum_valid = 1'b0;
        check_eq("idle_sum_err", 32'(err), 32'h1);
        check_eq("idle_sum_dropped", 32'(res_valid), 32'h0);
        do_reset();

        // 6: asynchronous abort in pass 2, then a clean repeat of row 2
        run_row(8, 3, 0, 20);
        run_row(8, 3, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
